// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO between NREQ packet sources; packets are never interleaved.
// Optional stall timeout for a granted requester is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              busy,
    output logic              abort
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   sel_idx;
    logic [NREQ-1:0] sel_onehot;
    logic            sel_valid;
    logic            cur_req;
    logic            cur_last;
    logic [7:0]      cur_data;

    // Out-of-range parameters elaborate this empty marker block.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 2) begin : g_param_range_violation
    end

    // Round robin: scan requesters above last_grant first, then wrap to the bottom.
    always_comb begin
        sel_idx    = last_grant;
        sel_valid  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_valid && req[i] && (IW'(i) > last_grant)) begin
                sel_idx   = IW'(i);
                sel_valid = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_valid && req[i] && (IW'(i) <= last_grant)) begin
                sel_idx   = IW'(i);
                sel_valid = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cur_req  = 1'b0;
        cur_last = 1'b0;
        cur_data = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                cur_req  = req[i];
                cur_last = req_last[i];
                cur_data = req_data[i*8 +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] stall_cnt;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= IW'(NREQ - 1);
            grant_idx  <= '0;
            grant      <= '0;
            ack        <= '0;
            wr_uart    <= 1'b0;
            w_data     <= 8'h00;
            busy       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            abort      <= 1'b0;
            stall_cnt  <= '0;
`endif
        end else begin
            ack     <= '0;
            wr_uart <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            abort   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                    if (sel_valid) begin
                        grant     <= sel_onehot;
                        grant_idx <= sel_idx;
                        busy      <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A write just issued blocks the next cycle so the requester can advance.
                    if (cur_req && !tx_full && !wr_uart) begin
                        wr_uart <= 1'b1;
                        w_data  <= cur_data;
                        ack     <= grant;
                        if (cur_last) begin
                            state <= S_DONE;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    if (cur_req) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        abort      <= 1'b1;
                        grant      <= '0;
                        busy       <= 1'b0;
                        last_grant <= grant_idx;
                        stall_cnt  <= '0;
                        state      <= S_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    last_grant <= grant_idx;
                    grant      <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
